// File: rtl/debug_frame_initiator.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_initiator
// Description : Sends a framed debug command over a byte-wide UART interface
//               (5A A5 op addr data [CHK]), then hunts for the 5A A5 reply
//               header, collects the reply body and reports status/payload.
//               An inactivity timer aborts a reply that never arrives.
//               Build option: define DEBUG_FRAME_CHECKSUM_EN to append and
//               verify a two's-complement checksum byte on both frames.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_frame_initiator #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        uart_tx_start,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_done,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_payload
);

`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam logic [3:0] TX_LAST = 4'd9;   // index of CHK in request frame
  localparam logic [2:0] RX_LAST = 3'd5;   // index of CHK in reply body
`else
  localparam logic [3:0] TX_LAST = 4'd8;
  localparam logic [2:0] RX_LAST = 3'd4;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_BYTE  = 3'd1,
    TX_WAIT  = 3'd2,
    RX_SYNC0 = 3'd3,
    RX_SYNC1 = 3'd4,
    RX_BODY  = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  ack_q, ack_d;
  logic [31:0] pay_q, pay_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] rsp_pay_q, rsp_pay_d;

  logic [3:0]  tx_sel;
  logic [7:0]  tx_next;
  logic [15:0] cnt_inc;
  logic        chk_bad;

  assign tx_sel  = tx_idx_q + 4'd1;
  assign cnt_inc = cnt_q + 16'd1;

`ifdef DEBUG_FRAME_CHECKSUM_EN
  logic [7:0] tx_chk;
  logic [7:0] rx_sum;
  // Request CHK makes the op/addr/data byte sum wrap to zero.
  assign tx_chk  = 8'd0 - (op_q + addr_q[15:8] + addr_q[7:0] + data_q[31:24] +
                           data_q[23:16] + data_q[15:8] + data_q[7:0]);
  // uart_rx_data is the reply CHK when this is consulted (last body byte).
  assign rx_sum  = ack_q + pay_q[31:24] + pay_q[23:16] + pay_q[15:8] +
                   pay_q[7:0] + uart_rx_data;
  assign chk_bad = (rx_sum != 8'd0);
`else
  assign chk_bad = 1'b0;
`endif

  // Byte that follows the one currently on uart_tx_data.
  always_comb begin
    tx_next = 8'h00;
    case (tx_sel)
      4'd1: tx_next = 8'hA5;
      4'd2: tx_next = op_q;
      4'd3: tx_next = addr_q[15:8];
      4'd4: tx_next = addr_q[7:0];
      4'd5: tx_next = data_q[31:24];
      4'd6: tx_next = data_q[23:16];
      4'd7: tx_next = data_q[15:8];
      4'd8: tx_next = data_q[7:0];
`ifdef DEBUG_FRAME_CHECKSUM_EN
      4'd9: tx_next = tx_chk;
`endif
      default: tx_next = 8'h00;
    endcase
  end

  // Next-state and output decode for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    tx_idx_d      = tx_idx_q;
    tx_data_d     = tx_data_q;
    rx_idx_d      = rx_idx_q;
    ack_d         = ack_q;
    pay_d         = pay_q;
    cnt_d         = cnt_q;
    status_d      = status_q;
    rsp_pay_d     = rsp_pay_q;
    cmd_ready     = 1'b0;
    uart_tx_start = 1'b0;
    rsp_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted even though the state is IDLE.
        cmd_ready = ~reset;
        if (cmd_valid) begin
          op_d      = cmd_op;
          addr_d    = cmd_addr;
          data_d    = cmd_data;
          tx_idx_d  = 4'd0;
          tx_data_d = 8'h5A;
          state_d   = TX_BYTE;
        end
      end
      TX_BYTE: begin
        uart_tx_start = 1'b1;
        state_d       = TX_WAIT;
      end
      TX_WAIT: begin
        if (uart_tx_done) begin
          if (tx_idx_q == TX_LAST) begin
            cnt_d   = 16'd0;
            state_d = RX_SYNC0;
          end else begin
            tx_idx_d  = tx_sel;
            tx_data_d = tx_next;
            state_d   = TX_BYTE;
          end
        end
      end
      RX_SYNC0, RX_SYNC1, RX_BODY: begin
        if (uart_rx_valid) begin
          // A received byte always restarts the inactivity window.
          cnt_d = 16'd0;
          case (state_q)
            RX_SYNC0: begin
              if (uart_rx_data == 8'h5A) state_d = RX_SYNC1;
            end
            RX_SYNC1: begin
              if (uart_rx_data == 8'hA5) begin
                rx_idx_d = 3'd0;
                state_d  = RX_BODY;
              end else if (uart_rx_data != 8'h5A) begin
                state_d = RX_SYNC0;
              end
            end
            default: begin
              rx_idx_d = rx_idx_q + 3'd1;
              case (rx_idx_q)
                3'd0:    ack_d         = uart_rx_data;
                3'd1:    pay_d[31:24]  = uart_rx_data;
                3'd2:    pay_d[23:16]  = uart_rx_data;
                3'd3:    pay_d[15:8]   = uart_rx_data;
                3'd4:    pay_d[7:0]    = uart_rx_data;
                default: pay_d         = pay_q;
              endcase
              if (rx_idx_q == RX_LAST) begin
                rsp_pay_d = pay_d;
                if (chk_bad)             status_d = 2'b01;
                else if (ack_q != op_q)  status_d = 2'b10;
                else                     status_d = 2'b00;
                state_d = DONE;
              end
            end
          endcase
        end else if (cnt_inc == TIMEOUT_CYCLES) begin
          cnt_d     = cnt_inc;
          status_d  = 2'b11;
          rsp_pay_d = 32'd0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= 8'd0;
      addr_q    <= 16'd0;
      data_q    <= 32'd0;
      tx_idx_q  <= 4'd0;
      tx_data_q <= 8'd0;
      rx_idx_q  <= 3'd0;
      ack_q     <= 8'd0;
      pay_q     <= 32'd0;
      cnt_q     <= 16'd0;
      status_q  <= 2'b00;
      rsp_pay_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_idx_q  <= tx_idx_d;
      tx_data_q <= tx_data_d;
      rx_idx_q  <= rx_idx_d;
      ack_q     <= ack_d;
      pay_q     <= pay_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      rsp_pay_q <= rsp_pay_d;
    end
  end

  assign uart_tx_data = tx_data_q;
  assign rsp_status   = status_q;
  assign rsp_payload  = rsp_pay_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_frame_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_frame_initiator
// Description : Self-checking bench for debug_frame_initiator: directed
//               vector table, hand-written corner sequences and randomized
//               transactions against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_frame_initiator;

  localparam logic [15:0] TO = 16'd100;
`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
    logic [7:0]  exp_chk;
    logic [7:0]  ack;
    logic [31:0] pay;
    bit          corrupt;
    logic [1:0]  exp_status;
  } vec_t;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        uart_tx_start, uart_tx_done;
  logic [7:0]  uart_tx_data;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_payload;

  int n_cmp  = 0;
  int n_fail = 0;
  int rsp_count = 0;

  debug_frame_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .uart_tx_done(uart_tx_done),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_payload(rsp_payload)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_count <= rsp_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Request frame from the field values, with the byte-sum checksum rule.
  function automatic bq_t model_tx(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d);
    bq_t q;
    int  s;
    q.push_back(8'h5A); q.push_back(8'hA5); q.push_back(op);
    q.push_back(a[15:8]); q.push_back(a[7:0]);
    q.push_back(d[31:24]); q.push_back(d[23:16]); q.push_back(d[15:8]); q.push_back(d[7:0]);
    s = int'(op) + int'(a[15:8]) + int'(a[7:0]) + int'(d[31:24]) + int'(d[23:16]) +
        int'(d[15:8]) + int'(d[7:0]);
    if (CHK_EN) q.push_back(8'((256 - (s % 256)) % 256));
    return q;
  endfunction

  // Reply byte stream: prefix, header, ack, payload, optional (maybe broken) CHK.
  function automatic bq_t build_reply(input bq_t pre, input logic [7:0] ack, input logic [31:0] p, input bit corrupt);
    bq_t q;
    int  s;
    q = pre;
    q.push_back(8'h5A); q.push_back(8'hA5); q.push_back(ack);
    q.push_back(p[31:24]); q.push_back(p[23:16]); q.push_back(p[15:8]); q.push_back(p[7:0]);
    s = int'(ack) + int'(p[31:24]) + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    if (CHK_EN) q.push_back(8'((256 - (s % 256)) % 256) ^ (corrupt ? 8'h55 : 8'h00));
    return q;
  endfunction

  // Body starts right after the first adjacent 5A,A5 pair in the stream.
  function automatic void model_rsp(input logic [7:0] op, input bq_t r,
                                    output logic [1:0] st, output logic [31:0] pay);
    int b = -1;
    int s = 0;
    for (int i = 0; i + 1 < r.size(); i++)
      if (b < 0 && r[i] == 8'h5A && r[i+1] == 8'hA5) b = i + 2;
    st  = 2'b11;
    pay = 32'd0;
    if (b >= 0) begin
      pay = {r[b+1], r[b+2], r[b+3], r[b+4]};
      if (CHK_EN) for (int j = 0; j < 6; j++) s += int'(r[b+j]);
      if ((s % 256) != 0)  st = 2'b01;
      else if (r[b] != op) st = 2'b10;
      else                 st = 2'b00;
    end
  endfunction

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d);
    int k = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("cmd_ready_wait", 32'(k < 50), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("tx_start_after_hs", 32'(uart_tx_start), 32'd1);
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  // Act as the UART transmitter for the first n bytes of the request.
  task automatic run_tx(input bq_t exq, input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      int gap;
      while (uart_tx_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      check($sformatf("tx_start_seen%0d", i), 32'(k < 20), 32'd1);
      check($sformatf("tx_byte%0d", i), 32'(uart_tx_data), 32'(exq[i]));
      @(negedge clk);
      check($sformatf("tx_start_pulse%0d", i), 32'(uart_tx_start), 32'd0);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      check($sformatf("tx_hold%0d", i), 32'(uart_tx_data), 32'(exq[i]));
      uart_tx_done = 1'b1;
      @(negedge clk);
      uart_tx_done = 1'b0;
    end
  endtask

  task automatic send_rx(input bq_t q, input int maxgap);
    for (int i = 0; i < q.size(); i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      uart_rx_valid = 1'b1;
      uart_rx_data  = q[i];
      @(negedge clk);
      uart_rx_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] es, input logic [31:0] ep, output int lat);
    int k = 0;
    while (rsp_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    lat = k;
    check({tag, "_rsp_seen"}, 32'(k < 300), 32'd1);
    check({tag, "_status"}, 32'(rsp_status), 32'(es));
    check({tag, "_payload"}, rsp_payload, ep);
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, "_status_held"}, 32'(rsp_status), 32'(es));
  endtask

  task automatic do_txn(input string tag, input logic [7:0] op, input logic [15:0] a, input logic [31:0] d,
                        input bq_t exq, input bq_t rep, input logic [1:0] es, input logic [31:0] ep);
    int lat;
    int c0 = rsp_count;
    send_cmd(op, a, d);
    run_tx(exq, exq.size());
    send_rx(rep, 2);
    wait_rsp(tag, es, ep, lat);
    check({tag, "_rsp_latency"}, lat, 32'd0);
    check({tag, "_rsp_count"}, rsp_count - c0, 32'd1);
  endtask

  initial begin
    vec_t        vecs[4];
    bq_t         exq, rep, pre;
    logic [1:0]  es;
    logic [31:0] ep;
    logic [7:0]  op, ack, g;
    logic [15:0] addr;
    logic [31:0] data, pay;
    int          lat, c0;

    // op/addr/data byte sums: 0x81, 0x01, 0x78, 0x33.
    vecs[0] = '{8'h03, 16'h1234, 32'hDEADBEEF, 8'h7F, 8'h03, 32'h00000001, 1'b0, 2'b00};
    vecs[1] = '{8'h01, 16'h0000, 32'h00000000, 8'hFF, 8'h01, 32'hCAFEF00D, 1'b0, 2'b00};
    vecs[2] = '{8'h7E, 16'hFFFF, 32'hFFFFFFFF, 8'h88, 8'h7F, 32'h12345678, 1'b0, 2'b10};
`ifdef DEBUG_FRAME_CHECKSUM_EN
    vecs[3] = '{8'h03, 16'h0010, 32'h00000020, 8'hCD, 8'h04, 32'h00000001, 1'b1, 2'b01};
`else
    vecs[3] = '{8'h03, 16'h0010, 32'h00000020, 8'hCD, 8'h04, 32'h00000001, 1'b1, 2'b10};
`endif

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    uart_tx_done = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;
    @(negedge clk); @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_tx_start", 32'(uart_tx_start), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data), 32'h00);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_rsp_payload", rsp_payload, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 4; i++) begin
      pre = {};
      exq = model_tx(vecs[i].op, vecs[i].addr, vecs[i].data);
      if (exq.size() == 10) exq[9] = vecs[i].exp_chk;
      rep = build_reply(pre, vecs[i].ack, vecs[i].pay, vecs[i].corrupt);
      do_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data,
             exq, rep, vecs[i].exp_status, vecs[i].pay);
    end

    // Garbage 11 5A ahead of 5A A5: sync recovers on the repeated 5A.
    pre = {};
    pre.push_back(8'h11); pre.push_back(8'h5A);
    rep = build_reply(pre, 8'h22, 32'hA5A55A5A, 1'b0);
    do_txn("garbage_sync", 8'h22, 16'hBEEF, 32'h01020304,
           model_tx(8'h22, 16'hBEEF, 32'h01020304), rep, 2'b00, 32'hA5A55A5A);

    // No reply at all: response exactly TO cycles after entering RX_SYNC0.
    send_cmd(8'h10, 16'h0001, 32'h00000002);
    run_tx(model_tx(8'h10, 16'h0001, 32'h00000002), CHK_EN ? 10 : 9);
    wait_rsp("timeout", 2'b11, 32'd0, lat);
    check("timeout_cycles", lat, 32'(TO));

    // A byte in the final cycle before timeout wins and restarts the window.
    send_cmd(8'h44, 16'h5555, 32'h66666666);
    run_tx(model_tx(8'h44, 16'h5555, 32'h66666666), CHK_EN ? 10 : 9);
    repeat (int'(TO) - 1) @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h11;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    check("byte_beats_timeout", 32'(rsp_valid), 32'd0);
    pre = {};
    rep = build_reply(pre, 8'h44, 32'h0BADF00D, 1'b0);
    send_rx(rep, 1);
    wait_rsp("after_near_timeout", 2'b00, 32'h0BADF00D, lat);

    // Reset after the third request byte abandons the transaction.
    c0 = rsp_count;
    send_cmd(8'h03, 16'h1234, 32'hDEADBEEF);
    run_tx(model_tx(8'h03, 16'h1234, 32'hDEADBEEF), 3);
    reset = 1'b1;
    #1;
    check("midrst_tx_start", 32'(uart_tx_start), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(cmd_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("midrst_no_rsp", rsp_count - c0, 32'd0);
    pre = {};
    do_txn("after_reset", 8'h03, 16'h1234, 32'hDEADBEEF,
           model_tx(8'h03, 16'h1234, 32'hDEADBEEF),
           build_reply(pre, 8'h03, 32'h00000001, 1'b0), 2'b00, 32'h00000001);

    // Randomized transactions against the frame-level model.
    for (int t = 0; t < 25; t++) begin
      op   = 8'($urandom_range(0, 255));
      addr = 16'($urandom);
      data = $urandom;
      pay  = $urandom;
      ack  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : op;
      pre  = {};
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h5A) g = 8'h11;
        pre.push_back(g);
      end
      rep = build_reply(pre, ack, pay, ($urandom_range(0, 3) == 0));
      model_rsp(op, rep, es, ep);
      do_txn($sformatf("rand%0d", t), op, addr, data, model_tx(op, addr, data), rep, es, ep);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute runtime bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
